sync_regs_mp: RTL and testbench

- Parametrised successor wrapper around the synchronous core register file RAM.
- Generates N read addresses and two write ports: writeback, plus direct-load `ldvalid`/`regadr`/`drd`.
- Provides a write-through history of configurable depth on every read port, and a host-read stall FSM.
- Sits between the pipeline stage 2/3 control and the RAM macro.

---
 rtl/sync_regs_mp_pkg.sv | 19 +
 rtl/sync_regs_wt_hist.sv | 57 +++++
 rtl/sync_regs_mp.sv | 194 +++++++++++++++++++
 tb/tb_sync_regs_mp.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_regs_mp_pkg.sv
// Shared types and helpers for the sync_regs_mp register-file wrapper.
// Holds the host FSM encoding, RAM control active levels and the core-range test.
package sync_regs_mp_pkg;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_ADDR = 2'd1,
    H_DATA = 2'd2
  } host_st_t;

  localparam logic REGFILE_WR_ACTIVE    = 1'b1;
  localparam logic REGFILE_CK_EN_ACTIVE = 1'b1;

  // True when the address falls inside the RAM-backed core register range.
  function automatic logic rf_reg(input logic [31:0] addr, input int core_w);
    return addr < (32'd1 << core_w);
  endfunction

endpackage

// File: rtl/sync_regs_wt_hist.sv
// Write-through history for one RAM write port: DEPTH entries of {valid, addr, data}, newest at index 0.
// Latency: a write is visible one cycle after it is pushed; per-read-port hit vectors are combinational.
module sync_regs_wt_hist
  import sync_regs_mp_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 1
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     i_push_vld,
  input  logic [ADDR_W-1:0]        i_push_addr,
  input  logic [DATA_W-1:0]        i_push_dat,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DEPTH-1:0]  o_hit,
  output logic [DEPTH*DATA_W-1:0]  o_ent_dat,
  output logic                     o_any_vld
);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_dat  [DEPTH];

  // Stage 0 only captures on a real write; older stages shift unconditionally.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_dat[i]  <= '0;
      end
    end else begin
      r_vld[0] <= i_push_vld;
      if (i_push_vld) begin
        r_addr[0] <= i_push_addr;
        r_dat[0]  <= i_push_dat;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_dat[i]  <= r_dat[i-1];
      end
    end
  end

  for (genvar a = 0; a < DEPTH; a++) begin : g_ent
    assign o_ent_dat[a*DATA_W +: DATA_W] = r_dat[a];
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign o_hit[k*DEPTH + a] = r_vld[a] & (r_addr[a] == i_rd_addr[k*ADDR_W +: ADDR_W]);
    end
  end

  assign o_any_vld = |r_vld;

endmodule

// File: rtl/sync_regs_mp.sv
// Register-file RAM wrapper: dual write ports, write-through bypass on NUM_RD read ports, host-read stall FSM.
// qd is combinational from rf_q; host data 2 cycles after request. `SYNC_REGS_MP_WT_STATS_EN adds wt_hits.
module sync_regs_mp
  import sync_regs_mp_pkg::*;
#(
  parameter int NUM_RD   = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int CORE_W   = 5,
  parameter int WT_DEPTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     en,
  input  logic                     en2,
  input  logic                     p2iv,
  input  logic                     test_mode,
  input  logic [NUM_RD*ADDR_W-1:0] rd_a,
  input  logic [NUM_RD*ADDR_W-1:0] p2_rd_a,
  input  logic                     hold_host,
  input  logic                     h_read,
  input  logic                     core_access,
  input  logic [ADDR_W-1:0]        h_addr,
  input  logic                     wben,
  input  logic [ADDR_W-1:0]        wba,
  input  logic [DATA_W-1:0]        wbdata,
  input  logic                     ldvalid,
  input  logic [ADDR_W-1:0]        regadr,
  input  logic [DATA_W-1:0]        drd,
  input  logic [NUM_RD*DATA_W-1:0] rf_q,
  output logic [NUM_RD*CORE_W-1:0] rf_ra,
  output logic [CORE_W-1:0]        rf_aw,
  output logic [CORE_W-1:0]        rf_aw2,
  output logic                     rf_we,
  output logic                     rf_we2,
  output logic                     ck_en_w,
  output logic                     ck_en_w2,
  output logic [NUM_RD-1:0]        ck_en_r,
  output logic [NUM_RD*DATA_W-1:0] qd,
  output logic                     sr_xhold_host_a,
  output logic                     h_rvalid
`ifdef SYNC_REGS_MP_WT_STATS_EN
  ,
  output logic [15:0]              wt_hits
`endif
);

  host_st_t                     r_st;
  host_st_t                     w_st_nxt;
  logic                         w_host_req;
  logic                         w_host_act;
  logic                         w_wb_we;
  logic                         w_ld_we;
  logic [NUM_RD*ADDR_W-1:0]     w_sel_a;
  logic [NUM_RD*WT_DEPTH-1:0]   w_wb_hit;
  logic [NUM_RD*WT_DEPTH-1:0]   w_ld_hit;
  logic [WT_DEPTH*DATA_W-1:0]   w_wb_hdat;
  logic [WT_DEPTH*DATA_W-1:0]   w_ld_hdat;
  logic                         w_wb_any;
  logic                         w_ld_any;
  logic                         w_ck_base;
  logic [NUM_RD-1:0]            w_ck_r;

  // Extension-space writes never reach the RAM; writeback wins a same-address collision.
  assign w_wb_we = wben & rf_reg(32'(wba), CORE_W);
  assign w_ld_we = ldvalid & rf_reg(32'(regadr), CORE_W) & ~(w_wb_we & (wba == regadr));

  assign rf_we    = w_wb_we ? REGFILE_WR_ACTIVE : ~REGFILE_WR_ACTIVE;
  assign rf_we2   = w_ld_we ? REGFILE_WR_ACTIVE : ~REGFILE_WR_ACTIVE;
  assign rf_aw    = wba[CORE_W-1:0];
  assign rf_aw2   = regadr[CORE_W-1:0];
  assign ck_en_w  = (w_wb_we | test_mode) ? REGFILE_CK_EN_ACTIVE : ~REGFILE_CK_EN_ACTIVE;
  assign ck_en_w2 = (w_ld_we | test_mode) ? REGFILE_CK_EN_ACTIVE : ~REGFILE_CK_EN_ACTIVE;

  assign w_host_act = (r_st != H_IDLE);

  always_comb begin
    w_sel_a = rd_a;
    if (en2) begin
      w_sel_a = p2_rd_a;
    end else if (w_host_act) begin
      w_sel_a[ADDR_W +: ADDR_W] = h_addr;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign rf_ra[k*CORE_W +: CORE_W] = w_sel_a[k*ADDR_W +: CORE_W];
  end

  sync_regs_wt_hist #(
    .NUM_RD (NUM_RD),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WT_DEPTH)
  ) u_wb_hist (
    .clk         (clk),
    .rst_a       (rst_a),
    .i_push_vld  (w_wb_we),
    .i_push_addr (wba),
    .i_push_dat  (wbdata),
    .i_rd_addr   (w_sel_a),
    .o_hit       (w_wb_hit),
    .o_ent_dat   (w_wb_hdat),
    .o_any_vld   (w_wb_any)
  );

  sync_regs_wt_hist #(
    .NUM_RD (NUM_RD),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WT_DEPTH)
  ) u_ld_hist (
    .clk         (clk),
    .rst_a       (rst_a),
    .i_push_vld  (w_ld_we),
    .i_push_addr (regadr),
    .i_push_dat  (drd),
    .i_rd_addr   (w_sel_a),
    .o_hit       (w_ld_hit),
    .o_ent_dat   (w_ld_hdat),
    .o_any_vld   (w_ld_any)
  );

  // Sources are applied lowest priority first so the last matching assignment wins.
  always_comb begin
    qd = rf_q;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int a = WT_DEPTH - 1; a >= 0; a--) begin
        if (w_ld_hit[k*WT_DEPTH + a]) qd[k*DATA_W +: DATA_W] = w_ld_hdat[a*DATA_W +: DATA_W];
        if (w_wb_hit[k*WT_DEPTH + a]) qd[k*DATA_W +: DATA_W] = w_wb_hdat[a*DATA_W +: DATA_W];
      end
      if (w_ld_we && (regadr == w_sel_a[k*ADDR_W +: ADDR_W])) qd[k*DATA_W +: DATA_W] = drd;
      if (w_wb_we && (wba == w_sel_a[k*ADDR_W +: ADDR_W])) qd[k*DATA_W +: DATA_W] = wbdata;
    end
  end

  assign w_ck_base = (p2iv & en2) | w_wb_we | w_ld_we | w_wb_any | w_ld_any | test_mode;

  always_comb begin
    w_ck_r    = {NUM_RD{w_ck_base}};
    w_ck_r[1] = w_ck_base | w_host_act;
    for (int k = 0; k < NUM_RD; k++) begin
      ck_en_r[k] = w_ck_r[k] ? REGFILE_CK_EN_ACTIVE : ~REGFILE_CK_EN_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) r_st <= H_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_host_req = 1'b0;
    case (r_st)
      H_IDLE: begin
        w_host_req = ~en & h_read & core_access & ~hold_host;
        if (w_host_req) w_st_nxt = H_ADDR;
      end
      H_ADDR:  w_st_nxt = en ? H_IDLE : H_DATA;
      H_DATA:  if (~h_read | en) w_st_nxt = H_IDLE;
      default: w_st_nxt = H_IDLE;
    endcase
  end

  assign sr_xhold_host_a = (r_st == H_ADDR) | w_host_req;
  assign h_rvalid        = (r_st == H_DATA);

`ifdef SYNC_REGS_MP_WT_STATS_EN
  logic        w_byp_any;
  logic [15:0] r_wt_hits;

  always_comb begin
    w_byp_any = (|w_wb_hit) | (|w_ld_hit);
    for (int k = 0; k < NUM_RD; k++) begin
      if ((w_wb_we && (wba == w_sel_a[k*ADDR_W +: ADDR_W])) ||
          (w_ld_we && (regadr == w_sel_a[k*ADDR_W +: ADDR_W]))) begin
        w_byp_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_wt_hits <= '0;
    end else if (p2iv & en2 & w_byp_any & (r_wt_hits != 16'hFFFF)) begin
      r_wt_hits <= r_wt_hits + 16'd1;
    end
  end

  assign wt_hits = r_wt_hits;
`endif

endmodule

// File: tb/tb_sync_regs_mp.sv
// Scoreboard bench for sync_regs_mp: a write-event log reference model predicts every output each cycle.
module tb_sync_regs_mp;
  localparam int NR = 2, DW = 32, AW = 6, CW = 5, WD = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en, en2, p2iv, test_mode, hold_host, h_read, core_access, wben, ldvalid;
  logic [NR*AW-1:0] rd_a, p2_rd_a;
  logic [AW-1:0]    h_addr, wba, regadr;
  logic [DW-1:0]    wbdata, drd;
  logic [NR*DW-1:0] rf_q, qd;
  logic [NR*CW-1:0] rf_ra;
  logic [CW-1:0]    rf_aw, rf_aw2;
  logic             rf_we, rf_we2, ck_en_w, ck_en_w2, sr_xhold_host_a, h_rvalid;
  logic [NR-1:0]    ck_en_r;
`ifdef SYNC_REGS_MP_WT_STATS_EN
  logic [15:0]      wt_hits;
`endif

  sync_regs_mp #(.NUM_RD(NR), .DATA_W(DW), .ADDR_W(AW), .CORE_W(CW), .WT_DEPTH(WD)) dut (
    .clk(clk), .rst_a(rst_a), .en(en), .en2(en2), .p2iv(p2iv), .test_mode(test_mode),
    .rd_a(rd_a), .p2_rd_a(p2_rd_a), .hold_host(hold_host), .h_read(h_read),
    .core_access(core_access), .h_addr(h_addr), .wben(wben), .wba(wba), .wbdata(wbdata),
    .ldvalid(ldvalid), .regadr(regadr), .drd(drd), .rf_q(rf_q), .rf_ra(rf_ra),
    .rf_aw(rf_aw), .rf_aw2(rf_aw2), .rf_we(rf_we), .rf_we2(rf_we2), .ck_en_w(ck_en_w),
    .ck_en_w2(ck_en_w2), .ck_en_r(ck_en_r), .qd(qd), .sr_xhold_host_a(sr_xhold_host_a),
    .h_rvalid(h_rvalid)
`ifdef SYNC_REGS_MP_WT_STATS_EN
    , .wt_hits(wt_hits)
`endif
  );

  typedef struct {
    logic [NR*DW-1:0] qd;
    logic [NR*CW-1:0] ra;
    logic [CW-1:0]    aw, aw2;
    logic             we, we2, ckw, ckw2, hold, rv;
    logic [NR-1:0]    ckr;
    logic [15:0]      hits;
  } exp_t;

  typedef struct {
    int            cyc;
    bit            src;   // 0 = writeback, 1 = direct load
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_ev_t;

  exp_t   sb_q[$];
  wr_ev_t ev_q[$];
  int     cyc = 0;
  int     m_st = 0;       // 0 idle, 1 address phase, 2 data phase
  int     m_hits = 0;
  bit     cur_hit;
  int     n_chk = 0, n_pass = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic bit m_we();
    return wben && (int'(wba) < (1 << CW));
  endfunction

  function automatic bit m_we2();
    return ldvalid && (int'(regadr) < (1 << CW)) && !(m_we() && wba == regadr);
  endfunction

  function automatic logic [AW-1:0] sel_addr(int k);
    if (en2) return p2_rd_a[k*AW +: AW];
    if (k == 1 && m_st != 0) return h_addr;
    return rd_a[k*AW +: AW];
  endfunction

  // Most recent write to this address within the write-through window; writeback wins a tie.
  function automatic bit lookup(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int best = -1;
    d = '0;
    if (m_we() && wba == a) begin d = wbdata; return 1; end
    if (m_we2() && regadr == a) begin d = drd; return 1; end
    foreach (ev_q[i]) begin
      if (ev_q[i].addr == a && ev_q[i].cyc >= cyc - WD &&
          (ev_q[i].cyc > best || (ev_q[i].cyc == best && ev_q[i].src == 1'b0))) begin
        best = ev_q[i].cyc;
        d    = ev_q[i].dat;
      end
    end
    return best >= 0;
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    bit any_hist = 0, base;
    cur_hit = 0;
    foreach (ev_q[i]) if (ev_q[i].cyc >= cyc - WD) any_hist = 1;
    for (int k = 0; k < NR; k++) begin
      a = sel_addr(k);
      e.ra[k*CW +: CW] = a[CW-1:0];
      if (lookup(a, d)) begin
        e.qd[k*DW +: DW] = d;
        cur_hit = 1;
      end else begin
        e.qd[k*DW +: DW] = rf_q[k*DW +: DW];
      end
    end
    e.we   = m_we();
    e.we2  = m_we2();
    e.aw   = wba[CW-1:0];
    e.aw2  = regadr[CW-1:0];
    e.ckw  = m_we() || test_mode;
    e.ckw2 = m_we2() || test_mode;
    base   = (p2iv && en2) || m_we() || m_we2() || any_hist || test_mode;
    e.ckr  = {NR{base}};
    e.ckr[1] = base || (m_st != 0);
    e.hold = (m_st == 1) || (m_st == 0 && !en && h_read && core_access && !hold_host);
    e.rv   = (m_st == 2);
    e.hits = 16'(m_hits);
    sb_q.push_back(e);
  endtask

  task automatic advance();
    if (!rst_a) begin
      ev_q.delete();
      m_st = 0;
      m_hits = 0;
    end else begin
      if (m_we())  ev_q.push_back('{cyc, 1'b0, wba, wbdata});
      if (m_we2()) ev_q.push_back('{cyc, 1'b1, regadr, drd});
      if (cur_hit && p2iv && en2 && m_hits < 65535) m_hits++;
      case (m_st)
        0:       if (!en && h_read && core_access && !hold_host) m_st = 1;
        1:       m_st = en ? 0 : 2;
        default: if (!h_read || en) m_st = 0;
      endcase
    end
    cyc++;
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc - WD) void'(ev_q.pop_front());
  endtask

  task automatic pre();  push_exp(); #1; endtask
  task automatic post(); @(posedge clk); #1; advance(); endtask
  task automatic step(); pre(); post(); endtask

  task automatic idle_inputs();
    rst_a = 1; en = 1; en2 = 0; p2iv = 0; test_mode = 0; hold_host = 0; h_read = 0;
    core_access = 0; h_addr = '0; wben = 0; wba = '0; wbdata = '0; ldvalid = 0;
    regadr = '0; drd = '0; rd_a = '0; p2_rd_a = '0; rf_q = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 4) == 0) return AW'(32 + $urandom_range(0, 7));
    return AW'($urandom_range(0, 7));
  endfunction

  // Monitor: DUT outputs are always presented, so one expectation is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("qd", 64'(qd), 64'(e.qd));
        chk("rf_ra", 64'(rf_ra), 64'(e.ra));
        chk("rf_aw", 64'(rf_aw), 64'(e.aw));
        chk("rf_aw2", 64'(rf_aw2), 64'(e.aw2));
        chk("rf_we", 64'(rf_we), 64'(e.we));
        chk("rf_we2", 64'(rf_we2), 64'(e.we2));
        chk("ck_en_w", 64'(ck_en_w), 64'(e.ckw));
        chk("ck_en_w2", 64'(ck_en_w2), 64'(e.ckw2));
        chk("ck_en_r", 64'(ck_en_r), 64'(e.ckr));
        chk("sr_xhold_host_a", 64'(sr_xhold_host_a), 64'(e.hold));
        chk("h_rvalid", 64'(h_rvalid), 64'(e.rv));
`ifdef SYNC_REGS_MP_WT_STATS_EN
        chk("wt_hits", 64'(wt_hits), 64'(e.hits));
`endif
      end
    end
  end

  initial begin
    idle_inputs();
    rst_a = 0;
    @(posedge clk); #1; advance();
    step();
    rst_a = 1;

    // Write-through of a writeback across the history window.
    wben = 1; wba = 6'd5; wbdata = 32'hDEADBEEF; rd_a = {6'd5, 6'd5};
    pre();
    chk("wt_age0_p0", 64'(qd[DW-1:0]), 64'hDEADBEEF);
    chk("wt_age0_p1", 64'(qd[2*DW-1:DW]), 64'hDEADBEEF);
    post();
    wben = 0;
    for (int i = 1; i <= WD; i++) begin
      pre();
      chk("wt_hist_p0", 64'(qd[DW-1:0]), 64'hDEADBEEF);
      chk("wt_hist_p1", 64'(qd[2*DW-1:DW]), 64'hDEADBEEF);
      post();
    end
    rf_q = {32'h0BADF00D, 32'h12345678};
    pre();
    chk("wt_expired", 64'(qd[DW-1:0]), 64'h12345678);
    post();

    // Same-address collision: writeback wins, load is suppressed.
    rf_q = '0; rd_a = {6'd3, 6'd3};
    wben = 1; wba = 6'd3; wbdata = 32'h11; ldvalid = 1; regadr = 6'd3; drd = 32'h22;
    pre();
    chk("collide_we2", 64'(rf_we2), 64'd0);
    chk("collide_qd", 64'(qd[DW-1:0]), 64'h11);
    post();
    wben = 0; ldvalid = 0;
    pre();
    chk("collide_age1", 64'(qd[DW-1:0]), 64'h11);
    post();
    step();

    // Extension-space writeback never reaches the RAM.
    wben = 1; wba = 6'd40; wbdata = 32'hCAFE;
    pre();
    chk("ext_we", 64'(rf_we), 64'd0);
    chk("ext_ckw", 64'(ck_en_w), 64'd0);
    post();
    test_mode = 1;
    pre();
    chk("ext_ckw_tm", 64'(ck_en_w), 64'd1);
    post();
    wben = 0; test_mode = 0;
    pre();
    chk("ext_ckr_idle", 64'(ck_en_r), 64'd0);
    post();

    // Host read of r7.
    en = 0; h_read = 1; core_access = 1; h_addr = 6'd7; rd_a = {6'd2, 6'd1};
    pre();
    chk("host_req_hold", 64'(sr_xhold_host_a), 64'd1);
    post();
    pre();
    chk("host_ra1", 64'(rf_ra[2*CW-1:CW]), 64'd7);
    post();
    rf_q = {32'hA5A5_0707, 32'h0000_0001};
    pre();
    chk("host_rvalid", 64'(h_rvalid), 64'd1);
    chk("host_qd1", 64'(qd[2*DW-1:DW]), 64'hA5A5_0707);
    post();
    h_read = 0;
    step();
    pre();
    chk("host_done", 64'(h_rvalid), 64'd0);
    post();

    // Reset during the address phase aborts the read and clears history.
    h_read = 1;
    step();
    rst_a = 0; h_read = 0; wben = 1; wba = 6'd9; wbdata = 32'h99;
    step();
    rst_a = 1; wben = 0; rd_a = {6'd9, 6'd9}; rf_q = {32'h5, 32'h6};
    pre();
    chk("rst_hold", 64'(sr_xhold_host_a), 64'd0);
    chk("rst_rvalid", 64'(h_rvalid), 64'd0);
    chk("rst_hist", 64'(qd[DW-1:0]), 64'h6);
    post();
    pre();
    chk("rst_rvalid2", 64'(h_rvalid), 64'd0);
    post();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rst_a = ($urandom_range(0, 63) != 0);
      en = ($urandom_range(0, 5) == 0);
      en2 = ($urandom_range(0, 2) == 0);
      p2iv = 1'($urandom);
      test_mode = ($urandom_range(0, 15) == 0);
      hold_host = ($urandom_range(0, 7) == 0);
      h_read = ($urandom_range(0, 3) != 0);
      core_access = ($urandom_range(0, 3) != 0);
      h_addr = rnd_addr();
      wben = 1'($urandom); wba = rnd_addr(); wbdata = $urandom;
      ldvalid = 1'($urandom); regadr = rnd_addr(); drd = $urandom;
      rd_a = {rnd_addr(), rnd_addr()}; p2_rd_a = {rnd_addr(), rnd_addr()};
      rf_q = {$urandom, $urandom};
      step();
    end

`ifdef SYNC_REGS_MP_WT_STATS_EN
    idle_inputs();
    rst_a = 0;
    step();
    rst_a = 1; en2 = 1; p2iv = 1; wben = 1; wba = 6'd5; p2_rd_a = {6'd5, 6'd5};
    for (int i = 0; i < 3; i++) begin
      wbdata = $urandom;
      step();
    end
    wben = 0; p2_rd_a = {6'd10, 6'd10};
    pre();
    chk("hits_three", 64'(wt_hits), 64'd3);
    post();
    wben = 1; p2_rd_a = {6'd5, 6'd5};
    for (int i = 0; i < 65540; i++) step();
    pre();
    chk("hits_saturated", 64'(wt_hits), 64'hFFFF);
    post();
`endif

    idle_inputs();
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
